sd_read_arbiter: RTL and testbench
==================================

Name: sd_read_arbiter

Overview:
- Shares the single sd_card block-read controller between N_REQ requesters, e.g. the tag scanner and a second block consumer.
- Each grant runs one complete 512-byte block read: the arbiter issues rd_req and block_addr, then steers the sd_dout/sd_valid stream to the owner with a byte index.
- Sits between the requester FSMs and sd_card. Replaces direct rd_req/rd_addr driving by the main FSM.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- BLK_BYTES, 512, bytes per block read.
- TIMEOUT_CYCLES, 1000000, idle-stream watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- init_finish  in  1  SD controller initialised.
- req  in  N_REQ  per-requester read request (level).
- req_addr  in  32*N_REQ  block address; requester i occupies bits [32*i +: 32].
- gnt  out  N_REQ  one-hot grant, held for the whole transfer.
- done  out  N_REQ  one-cycle pulse to the owner when its block completes.
- err  out  N_REQ  one-cycle error pulse (optional feature only; tied 0 otherwise).
- sd_rd_req  out  1  to sd_card rd_req.
- sd_block_addr  out  32  to sd_card block_addr.
- sd_dout  in  8  byte from sd_card.
- sd_valid  in  1  byte strobe from sd_card.
- byte_o  out  8  forwarded byte (equals sd_dout, combinational).
- byte_valid  out  N_REQ  sd_valid steered to the owner only.
- byte_idx  out  9  index 0..511 of the current byte.

Behaviour:
- Reset values:
  - State S_WAIT_INIT.
  - gnt, done, err = 0; sd_rd_req = 0; sd_block_addr = 0; byte_idx = 0.
  - Round-robin pointer = 0.
- S_WAIT_INIT: stay until init_finish = 1, then go to S_IDLE. init_finish is sampled only in this state.
- S_IDLE:
  - If any req is high, pick the winner round-robin, starting the search at the pointer.
  - Latch the winner's req_addr into sd_block_addr, set gnt one-hot, go to S_ISSUE.
  - If no req is high, stay.
- S_ISSUE: sd_rd_req = 1 for exactly one cycle, then go to S_XFER.
- S_XFER:
  - Each sd_valid increments byte_idx.
  - byte_valid[owner] = sd_valid in the same cycle; all other byte_valid bits are 0.
  - When the byte with byte_idx = BLK_BYTES-1 is accepted, go to S_DONE.
- S_DONE:
  - done[owner] = 1 for one cycle.
  - gnt clears; byte_idx = 0.
  - Pointer = owner+1, wrapping to 0 after N_REQ-1.
  - Go to S_IDLE. The earliest next grant is the following cycle.
- Grant latency: 1 cycle from req to gnt when in S_IDLE. sd_rd_req follows on the next cycle.
- Requester obligations:
  - Keep req high until done. Deassert req in the done cycle, or re-request the next block by keeping it high.
  - If req drops mid-transfer, the transfer still completes, because sd_card cannot abort. done still pulses and bytes are still steered to the owner.
- Address changes after the grant are ignored; the address is latched.
- Simultaneous requests: the lowest index at or after the pointer wins. Two back-to-back requesters therefore alternate A, B, A, B.
- sd_valid outside S_XFER is ignored: not forwarded, no counting.
- Reset mid-transfer: the arbiter returns to S_WAIT_INIT immediately, with no done pulse. sd_card is reset by the same signal.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts cycles in S_ISSUE/S_XFER since the last sd_valid.
  - When the count reaches TIMEOUT_CYCLES, err[owner] and done[owner] pulse together, gnt clears, the pointer advances, and the state returns to S_WAIT_INIT.
- Without the macro: no counter is built, err is constant 0, and the arbiter waits in S_XFER indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - State enum: S_WAIT_INIT, S_IDLE, S_ISSUE, S_XFER, S_DONE.
  - BLK_BYTES default.
  - Width constant for byte_idx (9).
  - Requester-ID width function (clog2 of N_REQ).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and winner index.
  - Instantiated once.

Test Plan:
- No init: init_finish = 0, req = 01 for 100 cycles -> gnt stays 00, sd_rd_req stays 0. Then raise init_finish -> gnt = 01 two cycles later.
- Single request: req0 with addr 0x2000 -> sd_block_addr = 0x2000, one-cycle sd_rd_req. Feed 512 sd_valid bytes with values 0..255 repeating -> byte_valid[0] pulses 512 times, byte_idx 0..511, done[0] one cycle after the last byte, byte_valid[1] never asserts.
- Contention: req = 11 held continuously, addr0 = 0x2000, addr1 = 0x3000 -> grant order 0, 1, 0, 1; sd_block_addr alternates 0x2000, 0x3000.
- Mid-transfer drop and address change: req0 drops at byte 100 and addr0 changes to 0x5000 -> transfer still finishes 512 bytes at 0x2000, done[0] pulses.
- Reset at byte 300: arbiter returns to S_WAIT_INIT next cycle with all outputs at reset values and no done pulse. Re-init with req1 -> gnt = 10 (pointer reset to 0, req0 low).
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 50: stop sd_valid at byte 10 -> err[0] and done[0] pulse exactly 50 cycles after the last byte, then state S_WAIT_INIT.

Source files
------------

// File: rtl/sd_read_arbiter_pkg.sv
// Shared types and constants for the SD block-read arbiter (package sd_arb_pkg).
// Used by sd_read_arbiter and its round-robin picker rr_pick.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DONE
    } state_t;

    localparam int BLK_BYTES_DEF = 512;
    localparam int BYTE_IDX_W    = 9;

    // Requester-ID width; a single requester still gets one bit.
    function automatic int req_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sd_read_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest requester index at or after ptr wins.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int ID_W = req_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    localparam int CW = ID_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    // Walk N_REQ candidates starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found                = 1'b1;
                gnt[cand[ID_W-1:0]]  = 1'b1;
                idx                  = cand[ID_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one sd_card block-read controller between N_REQ requesters, one 512-byte block per grant.
// Optional idle-stream watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_read_arbiter
    import sd_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int BLK_BYTES      = BLK_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_finish,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic                  sd_rd_req,
    output logic [31:0]           sd_block_addr,
    input  logic [7:0]            sd_dout,
    input  logic                  sd_valid,
    output logic [7:0]            byte_o,
    output logic [N_REQ-1:0]      byte_valid,
    output logic [BYTE_IDX_W-1:0] byte_idx
);

    localparam int ID_W = req_id_w(N_REQ);
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BLK_BYTES - 1);

    if (N_REQ < 2 || N_REQ > 4 || BLK_BYTES < 1 || BLK_BYTES > 512 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sd_read_arbiter: parameter out of range");
    end

    state_t           state, state_n;
    logic [ID_W-1:0]  ptr, owner, win_idx, ptr_next;
    logic [N_REQ-1:0] win_oh, owner_oh;
    logic             any_req, last_byte, wd_fire, to_q;
    logic [31:0]      addr_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[32*g +: 32];
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (win_oh),
        .idx (win_idx),
        .any (any_req)
    );

    assign last_byte = (state == S_XFER) && sd_valid && (byte_idx == LAST_IDX);
    assign ptr_next  = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_n = state;
        case (state)
            S_WAIT_INIT: if (init_finish) state_n = S_IDLE;
            S_IDLE:      if (any_req) state_n = S_ISSUE;
            S_ISSUE:     state_n = S_XFER;
            S_XFER:      if (last_byte) state_n = S_DONE;
            S_DONE:      state_n = S_IDLE;
            default:     state_n = S_WAIT_INIT;
        endcase
        if (wd_fire) state_n = S_WAIT_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_WAIT_INIT;
            ptr           <= '0;
            owner         <= '0;
            owner_oh      <= '0;
            sd_block_addr <= '0;
            byte_idx      <= '0;
        end else begin
            state <= state_n;
            // The address is captured once at grant; later req_addr changes are ignored.
            if (state == S_IDLE && any_req) begin
                owner         <= win_idx;
                owner_oh      <= win_oh;
                sd_block_addr <= addr_arr[win_idx];
            end
            if (state == S_XFER && sd_valid) begin
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
            if (state == S_DONE || wd_fire) begin
                byte_idx <= '0;
                ptr      <= ptr_next;
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counts cycles since the last byte (or since the read was issued).
    assign wd_fire = (state == S_ISSUE || (state == S_XFER && !sd_valid))
                     && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= wd_fire;
            if (wd_fire || !(state == S_ISSUE || state == S_XFER) || (state == S_XFER && sd_valid))
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign err = to_q ? owner_oh : '0;
`else
    assign wd_fire = 1'b0;
    assign to_q    = 1'b0;
    assign err     = '0;
`endif

    assign gnt        = (state == S_ISSUE || state == S_XFER) ? owner_oh : '0;
    assign done       = (state == S_DONE || to_q) ? owner_oh : '0;
    assign sd_rd_req  = (state == S_ISSUE);
    assign byte_o     = sd_dout;
    assign byte_valid = (state == S_XFER && sd_valid) ? owner_oh : '0;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Randomized self-checking bench for sd_read_arbiter (default build, watchdog disabled).
module tb_sd_read_arbiter;

    localparam int N   = 2;
    localparam int BLK = 512;

    logic             clk = 1'b0;
    logic             reset;
    logic             init_finish;
    logic [N-1:0]     req;
    logic [32*N-1:0]  req_addr;
    logic [N-1:0]     gnt, done, err, byte_valid;
    logic             sd_rd_req, sd_valid;
    logic [31:0]      sd_block_addr;
    logic [7:0]       sd_dout, byte_o;
    logic [8:0]       byte_idx;

    sd_read_arbiter #(.N_REQ(N), .BLK_BYTES(BLK), .TIMEOUT_CYCLES(1000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .init_finish   (init_finish),
        .req           (req),
        .req_addr      (req_addr),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .sd_rd_req     (sd_rd_req),
        .sd_block_addr (sd_block_addr),
        .sd_dout       (sd_dout),
        .sd_valid      (sd_valid),
        .byte_o        (byte_o),
        .byte_valid    (byte_valid),
        .byte_idx      (byte_idx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_ptr = 0;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int          cur_owner = 0;
    int          err_seen  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (err != '0) err_seen++;
            if (byte_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("byte_valid_spurious", 64'(byte_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("byte_valid_owner", 64'(byte_valid), 64'(onehot(cur_owner)));
                    check_eq("byte_idx", 64'(byte_idx), 64'(e[16:8]));
                    check_eq("byte_o", 64'(byte_o), 64'(e[7:0]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic serve_block(input int owner, input logic [31:0] addr, input int drop_at,
                               input logic [31:0] new_addr, input int reset_at,
                               input bit release_req, output int lat);
        int sent;
        bit first;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sd_rd_req) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check_eq("issue_wait_expired", 64'(0), 64'(1));
            return;
        end
        cur_owner = owner;
        check_eq("gnt_at_issue", 64'(gnt), 64'(onehot(owner)));
        check_eq("block_addr", 64'(sd_block_addr), 64'(addr));
        sent  = 0;
        first = 1'b1;
        while (sent < BLK) begin
            @(posedge clk); #1;
            if (sent == reset_at) begin
                sd_valid = 1'b0;
                reset    = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_eq("rst_gnt", 64'(gnt), 64'(0));
                check_eq("rst_done", 64'(done), 64'(0));
                check_eq("rst_rd_req", 64'(sd_rd_req), 64'(0));
                check_eq("rst_addr", 64'(sd_block_addr), 64'(0));
                check_eq("rst_byte_idx", 64'(byte_idx), 64'(0));
                @(posedge clk); #1;
                reset = 1'b0;
                exp_q.delete();
                m_ptr = 0;
                return;
            end
            if (sent == drop_at) begin
                req[owner] = 1'b0;
                req_addr[32*owner +: 32] = new_addr;
            end
            sd_valid = ($urandom_range(0, 3) != 0);
            sd_dout  = sd_valid ? 8'(sent % 256) : 8'($urandom);
            if (sd_valid) begin
                exp_q.push_back({9'(sent), 8'(sent % 256)});
                sent++;
            end
            if (first) begin
                first = 1'b0;
                @(negedge clk);
                check_eq("rd_req_one_cycle", 64'(sd_rd_req), 64'(0));
            end
        end
        // A stray strobe in the done cycle must not be forwarded.
        @(posedge clk); #1;
        sd_valid = 1'b1;
        sd_dout  = 8'($urandom);
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'(onehot(owner)));
        check_eq("gnt_clear_at_done", 64'(gnt), 64'(0));
        check_eq("byte_idx_at_done", 64'(byte_idx), 64'(0));
        check_eq("bytes_all_forwarded", 64'(exp_q.size()), 64'(0));
        sd_valid = 1'b0;
        if (release_req) req[owner] = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done), 64'(0));
        m_ptr = (owner + 1) % N;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bad, owner;
        reset = 1'b1; init_finish = 1'b0; req = '0; req_addr = '0;
        sd_valid = 1'b0; sd_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_gnt", 64'(gnt), 64'(0));
        check_eq("reset_done", 64'(done), 64'(0));
        check_eq("reset_err", 64'(err), 64'(0));
        check_eq("reset_rd_req", 64'(sd_rd_req), 64'(0));
        check_eq("reset_addr", 64'(sd_block_addr), 64'(0));
        check_eq("reset_byte_idx", 64'(byte_idx), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0;

        // Controller not initialised: requests and strobes must be ignored.
        req = 2'b01;
        req_addr[31:0] = 32'h2000;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            sd_valid = 1'($urandom_range(0, 1));
            sd_dout  = 8'($urandom);
            @(negedge clk);
            if (gnt != '0 || sd_rd_req) bad++;
        end
        check_eq("no_init_quiet_cycles", 64'(bad), 64'(0));
        check_eq("no_init_byte_idx", 64'(byte_idx), 64'(0));
        @(posedge clk); #1;
        sd_valid = 1'b0;
        init_finish = 1'b1;

        // Single request.
        owner = model_pick(req, m_ptr);
        serve_block(owner, 32'h2000, -1, 32'h0, -1, 1'b1, lat);
        check_eq("init_grant_latency", 64'(lat), 64'(2));

        // Request dropped and address changed mid-transfer.
        req = 2'b01;
        req_addr = {32'($urandom), 32'h2000};
        owner = model_pick(req, m_ptr);
        serve_block(owner, 32'h2000, 100, 32'h5000, -1, 1'b1, lat);

        // Reset at byte 300, then re-initialise with only requester 1.
        req = 2'b01;
        req_addr[31:0] = 32'h2000;
        owner = model_pick(req, m_ptr);
        serve_block(owner, 32'h2000, -1, 32'h0, 300, 1'b0, lat);
        req = 2'b10;
        req_addr = {32'h3000, 32'h2000};
        owner = model_pick(req, m_ptr);
        serve_block(owner, 32'h3000, -1, 32'h0, -1, 1'b1, lat);
        check_eq("reinit_grant_latency", 64'(lat), 64'(2));

        // Contention: both requesters held high.
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            owner = model_pick(req, m_ptr);
            serve_block(owner, (owner == 1) ? 32'h3000 : 32'h2000, -1, 32'h0, -1, 1'b0, lat);
        end
        req = '0;
        repeat (3) @(negedge clk);
        check_eq("err_never_pulsed", 64'(err_seen), 64'(0));
        check_eq("final_gnt_idle", 64'(gnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL global_time_limit: run exceeded its time budget");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
